// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter.
//   arb_state_t : arbiter FSM states
//   LINE_WIDTH  : width of one cache line in bits
package rv32i_types;

  localparam int LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between an I-side (read-only)
// and a D-side (read/write) cache. Only one transaction is in flight at a time.
// Each grant is followed by a single DONE cycle, so a requester that still
// holds its request for one cycle after its resp is not served twice.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_address/i_read            I-side request (held until i_resp)
//   i_rdata/i_resp              I-side read line and completion pulse
//   d_address/d_read/d_write    D-side request (held until d_resp)
//   d_wdata                     D-side write line
//   d_rdata/d_resp              D-side read line and completion pulse
//   pmem_*                      physical memory command/data/completion
//
// Configuration
//   MEM_ARBITER_ROUND_ROBIN_EN  defined: alternate on simultaneous requests
//                               undefined: D-side always wins
module mem_arbiter
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           i_address,
  input  logic                  i_read,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [31:0]           d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [31:0]           pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            r_state, w_next;
  logic [31:0]           r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_write;

  logic w_i_req, w_d_req, w_any_req, w_grant_d;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  assign w_any_req = w_i_req | w_d_req;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // r_last_d = 1 means D was served last, so I wins the next tie.
  logic r_last_d;
  logic r_sel_d;
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b1;
      r_sel_d  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any_req) r_sel_d <= w_grant_d;
      if (r_state == DONE) r_last_d <= r_sel_d;
    end
  end
`else
  assign w_grant_d = w_d_req;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = w_grant_d ? SERVE_D : SERVE_I;
      SERVE_I: if (pmem_resp) w_next = DONE;
      SERVE_D: if (pmem_resp) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request fields are captured at grant; the pmem side only ever sees these
  // copies, so the requester may change its inputs mid-transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any_req) begin
        r_addr  <= w_grant_d ? d_address : i_address;
        r_write <= w_grant_d & d_write;
        if (w_grant_d & d_write) r_wdata <= d_wdata;
      end
    end
  end

  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    case (r_state)
      SERVE_I: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp;
        if (pmem_resp) i_rdata = pmem_rdata;
      end
      SERVE_D: begin
        pmem_write = r_write;
        pmem_read  = ~r_write;
        d_resp     = pmem_resp;
        if (pmem_resp) d_rdata = pmem_rdata;
      end
      default: ;
    endcase
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import rv32i_types::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [31:0]           i_address;
  logic                  i_read;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic [31:0]           d_address;
  logic                  d_read;
  logic                  d_write;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic [31:0]           pmem_address;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  localparam logic [LINE_WIDTH-1:0] A5   = {32{8'hA5}};
  localparam logic [LINE_WIDTH-1:0] WD0  = {8{32'h1234_5678}};
  localparam logic [LINE_WIDTH-1:0] WD1  = {8{32'hDEAD_BEEF}};
  localparam logic [LINE_WIDTH-1:0] RDD  = {16{16'h5A3C}};

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Advance one rising edge; inputs are driven 2 time units after it and
  // outputs sampled 1 unit later, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = 0; d_address = 0; d_wdata = 0; pmem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    tot_cnt++; if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0)
      $display("FAIL reset_ctrl got %b exp 0000", {pmem_read, pmem_write, i_resp, d_resp}); else pass_cnt++;
    tot_cnt++; if (pmem_address !== 32'h0 || pmem_wdata !== '0)
      $display("FAIL reset_regs addr %h exp 0, wdata nonzero=%0d", pmem_address, pmem_wdata != '0); else pass_cnt++;
    tot_cnt++; if (i_rdata !== '0 || d_rdata !== '0)
      $display("FAIL reset_rdata got nonzero exp 0"); else pass_cnt++;
  endtask

  task automatic test_i_read();
    i_read = 1; i_address = 32'h60;
    tick(); #1;
    tot_cnt++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0)
      $display("FAIL i_cmd got rd=%b wr=%b exp rd=1 wr=0", pmem_read, pmem_write); else pass_cnt++;
    tot_cnt++; if (pmem_address !== 32'h60)
      $display("FAIL i_addr got %h exp 00000060", pmem_address); else pass_cnt++;
    tot_cnt++; if (i_resp !== 1'b0 || i_rdata !== '0)
      $display("FAIL i_early_resp got resp=%b exp 0 and rdata 0", i_resp); else pass_cnt++;
    tick(); tick(); tick();
    pmem_resp = 1; pmem_rdata = A5;
    #1;
    tot_cnt++; if (i_resp !== 1'b1 || d_resp !== 1'b0)
      $display("FAIL i_resp got i=%b d=%b exp i=1 d=0", i_resp, d_resp); else pass_cnt++;
    tot_cnt++; if (i_rdata !== A5)
      $display("FAIL i_rdata got %h exp %h", i_rdata, A5); else pass_cnt++;
    tick();
    // DONE cycle: requester drops now, pmem idle
    i_read = 0; pmem_resp = 0;
    #1;
    tot_cnt++; if ({pmem_read, pmem_write, i_resp} !== 3'b0)
      $display("FAIL i_done got %b exp 000", {pmem_read, pmem_write, i_resp}); else pass_cnt++;
    tick(); #1;
    tot_cnt++; if (pmem_read !== 1'b0)
      $display("FAIL i_idle got rd=%b exp 0", pmem_read); else pass_cnt++;
  endtask

  // Requester holds i_read through DONE: no command during DONE, then a
  // fresh transaction starts because i_read is still high in IDLE.
  task automatic test_held_request();
    i_read = 1; i_address = 32'h20;
    tick();
    pmem_resp = 1; pmem_rdata = RDD;
    #1;
    tot_cnt++; if (i_resp !== 1'b1 || i_rdata !== RDD)
      $display("FAIL held_resp got resp=%b exp 1", i_resp); else pass_cnt++;
    tick();
    pmem_resp = 0; pmem_rdata = 0;
    #1;
    tot_cnt++; if (pmem_read !== 1'b0 || i_resp !== 1'b0)
      $display("FAIL held_done got rd=%b resp=%b exp 0 0", pmem_read, i_resp); else pass_cnt++;
    tick(); #1;  // IDLE
    tot_cnt++; if (pmem_read !== 1'b0)
      $display("FAIL held_idle got rd=%b exp 0", pmem_read); else pass_cnt++;
    tick(); #1;  // SERVE_I again
    tot_cnt++; if (pmem_read !== 1'b1 || pmem_address !== 32'h20)
      $display("FAIL held_regrant got rd=%b addr=%h exp 1 00000020", pmem_read, pmem_address); else pass_cnt++;
    pmem_resp = 1;
    tick();
    i_read = 0; pmem_resp = 0;
    tick();
  endtask

  // Serve whatever is granted now; requests dropped in DONE, return in IDLE.
  task automatic finish_txn();
    pmem_resp = 1;
    tick();
    pmem_resp = 0; i_read = 0; d_read = 0; d_write = 0;
    tick();
  endtask

`ifndef MEM_ARBITER_ROUND_ROBIN_EN
  task automatic test_priority();
    i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h200;
    tick(); #1;
    tot_cnt++; if (pmem_address !== 32'h200 || pmem_read !== 1'b1)
      $display("FAIL prio_d_first got addr=%h rd=%b exp 00000200 1", pmem_address, pmem_read); else pass_cnt++;
    pmem_resp = 1; pmem_rdata = RDD;
    #1;
    tot_cnt++; if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== RDD || i_rdata !== '0)
      $display("FAIL prio_d_resp got d=%b i=%b exp d=1 i=0", d_resp, i_resp); else pass_cnt++;
    tick();
    pmem_resp = 0; d_read = 0;
    #1;
    tot_cnt++; if (pmem_read !== 1'b0)
      $display("FAIL prio_done got rd=%b exp 0", pmem_read); else pass_cnt++;
    tick(); tick(); #1;
    tot_cnt++; if (pmem_address !== 32'h100 || pmem_read !== 1'b1)
      $display("FAIL prio_i_second got addr=%h rd=%b exp 00000100 1", pmem_address, pmem_read); else pass_cnt++;
    finish_txn();
  endtask
`else
  task automatic test_round_robin();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h100;
    for (int r = 0; r < 3; r++) begin
      i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h200;
      tick(); #1;
      tot_cnt++; if (pmem_address !== exp_addr[r] || pmem_read !== 1'b1)
        $display("FAIL rr_round%0d got addr=%h exp %h", r, pmem_address, exp_addr[r]); else pass_cnt++;
      finish_txn();
    end
  endtask
`endif

  // Write with d_read also high (treated as a write); d_wdata changes after grant.
  task automatic test_d_write();
    d_write = 1; d_read = 1; d_address = 32'h40; d_wdata = WD0;
    tick(); #1;
    tot_cnt++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0)
      $display("FAIL dw_cmd got wr=%b rd=%b exp 1 0", pmem_write, pmem_read); else pass_cnt++;
    tot_cnt++; if (pmem_address !== 32'h40 || pmem_wdata !== WD0)
      $display("FAIL dw_latch got addr=%h exp 00000040", pmem_address); else pass_cnt++;
    d_wdata = WD1;
    tick(); #1;
    tot_cnt++; if (pmem_wdata !== WD0)
      $display("FAIL dw_hold got %h exp %h", pmem_wdata, WD0); else pass_cnt++;
    pmem_resp = 1;
    #1;
    tot_cnt++; if (d_resp !== 1'b1 || pmem_wdata !== WD0 || i_resp !== 1'b0)
      $display("FAIL dw_resp got d_resp=%b exp 1 with held wdata", d_resp); else pass_cnt++;
    tick();
    pmem_resp = 0; d_write = 0; d_read = 0;
    tick();
  endtask

  task automatic test_mid_reset();
    i_read = 1; i_address = 32'h80;
    tick(); #1;
    tot_cnt++; if (pmem_read !== 1'b1)
      $display("FAIL mr_serve got rd=%b exp 1", pmem_read); else pass_cnt++;
    rst = 1;
    tick();
    rst = 0; i_read = 0;
    #1;
    tot_cnt++; if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_address !== 32'h0)
      $display("FAIL mr_outputs got ctrl=%b addr=%h exp 0000 00000000",
               {pmem_read, pmem_write, i_resp, d_resp}, pmem_address); else pass_cnt++;
    pmem_resp = 1; pmem_rdata = A5;
    #1;
    tot_cnt++; if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0)
      $display("FAIL mr_late_resp got i=%b d=%b exp 0 0", i_resp, d_resp); else pass_cnt++;
    tick();
    pmem_resp = 0; pmem_rdata = 0;
    #1;
    tot_cnt++; if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0)
      $display("FAIL mr_after got %b exp 0000", {pmem_read, pmem_write, i_resp, d_resp}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_held_request();
`ifndef MEM_ARBITER_ROUND_ROBIN_EN
    test_priority();
`else
    test_round_robin();
`endif
    test_d_write();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
